packet_queue: RTL and testbench



---
 rtl/packet_queue_pkg.sv | 40 ++++
 rtl/packet_queue_if.sv | 32 +++
 rtl/packet_queue_assembler.sv | 115 +++++++++++
 rtl/packet_queue.sv | 127 ++++++++++++
 tb/tb_packet_queue.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/packet_queue_pkg.sv
// Shared constants, flit type codes and helpers for the MESSAGE2PACKET queue.
package packet_queue_pkg;
  localparam int QUEUE_WIDTH            = 4;
  localparam int N_BITS_POINTER         = 2;
  localparam int BUS_DATA_WIDTH         = 32;
  localparam int BUS_SEL_WIDTH          = 4;
  localparam int MAX_BURST_LENGHT       = 8;
  localparam int N_BITS_BURST_LENGHT    = 4;
  localparam int N_BITS_PKT_LEN         = 4;
  localparam int HEAD_FLIT_ADDRESS_BITS = 22;
  localparam int SRC_BITS_HEAD_FLIT     = 4;
  localparam int CMD_BITS_HEAD_FLIT     = 4;
  localparam int FLIT_TYPE_BITS         = 2;
  localparam int HEAD_FIELDS_W = CMD_BITS_HEAD_FLIT + SRC_BITS_HEAD_FLIT + HEAD_FLIT_ADDRESS_BITS;
  localparam int OUT_LINK_W    = (MAX_BURST_LENGHT + 1) * BUS_DATA_WIDTH;

  typedef enum logic [FLIT_TYPE_BITS-1:0] {
    FLIT_HEAD      = 2'b00,
    FLIT_BODY      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } asm_state_e;

  function automatic logic [BUS_DATA_WIDTH-1:0] mask_bytes(
    input logic [BUS_DATA_WIDTH-1:0] data,
    input logic [BUS_SEL_WIDTH-1:0]  sel
  );
    logic [BUS_DATA_WIDTH-1:0] res;
    res = '0;
    for (int b = 0; b < BUS_SEL_WIDTH; b++) begin
      res[8*b +: 8] = sel[b] ? data[8*b +: 8] : 8'h00;
    end
    return res;
  endfunction
endpackage

// File: rtl/packet_queue_if.sv
// Message-in (from wb_slave_interface) and packet-out (to flit buffer) signals.
interface packet_queue_if;
  import packet_queue_pkg::*;

  logic [HEAD_FLIT_ADDRESS_BITS-1:0] address_i;
  logic [SRC_BITS_HEAD_FLIT-1:0]     tga_i;
  logic [CMD_BITS_HEAD_FLIT-1:0]     tgc_i;
  logic                              we_i;
  logic [BUS_DATA_WIDTH-1:0]         data_i;
  logic [BUS_SEL_WIDTH-1:0]          sel_i;
  logic                              store_data_i;
  logic                              message_complete_i;
  logic                              abort_i;
  logic                              space_available_o;
  logic                              overflow_o;
  logic                              r_msg_to_pkt_o;
  logic                              g_msg_to_pkt_i;
  logic [OUT_LINK_W-1:0]             out_link_o;
  logic [N_BITS_PKT_LEN-1:0]         out_len_o;

  modport master (
    output address_i, tga_i, tgc_i, we_i, data_i, sel_i,
           store_data_i, message_complete_i, abort_i, g_msg_to_pkt_i,
    input  space_available_o, overflow_o, r_msg_to_pkt_o, out_link_o, out_len_o
  );

  modport slave (
    input  address_i, tga_i, tgc_i, we_i, data_i, sel_i,
           store_data_i, message_complete_i, abort_i, g_msg_to_pkt_i,
    output space_available_o, overflow_o, r_msg_to_pkt_o, out_link_o, out_len_o
  );
endinterface

// File: rtl/packet_queue_assembler.sv
// Assembly FSM: turns store/complete/abort strobes into slot write commands
// (head capture, masked word writes, commit) for the queue owned by the top.
module packet_queue_assembler
  import packet_queue_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             space_available_i,
  input  logic                             store_data_i,
  input  logic                             message_complete_i,
  input  logic                             abort_i,
  input  logic                             we_i,
  input  logic [BUS_DATA_WIDTH-1:0]        data_i,
  input  logic [BUS_SEL_WIDTH-1:0]         sel_i,
  output logic                             head_wr_o,
  output logic                             word_wr_o,
  output logic [N_BITS_BURST_LENGHT-2:0]   word_idx_o,
  output logic [BUS_DATA_WIDTH-1:0]        word_o,
  output logic                             commit_o,
  output logic [N_BITS_BURST_LENGHT-1:0]   commit_count_o,
  output logic                             overflow_o
);
  localparam logic [N_BITS_BURST_LENGHT-1:0] MAX_CNT = N_BITS_BURST_LENGHT'(MAX_BURST_LENGHT);

  asm_state_e                     state_q, state_d;
  logic [N_BITS_BURST_LENGHT-1:0] count_q, count_d;
  logic [N_BITS_BURST_LENGHT-1:0] count_nxt;
  logic                           we_q, we_d;
  logic                           overflow_q, overflow_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      we_q       <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      we_q       <= we_d;
      overflow_q <= overflow_d;
    end
  end

  // count_nxt is the word count including this cycle's word; it is what a commit records.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    we_d       = we_q;
    overflow_d = 1'b0;
    count_nxt  = count_q;
    head_wr_o  = 1'b0;
    word_wr_o  = 1'b0;
    word_idx_o = count_q[N_BITS_BURST_LENGHT-2:0];
    word_o     = mask_bytes(data_i, sel_i);
    commit_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (abort_i || !space_available_i) begin
          count_d = '0;
        end else if (store_data_i || message_complete_i) begin
          head_wr_o = 1'b1;
          we_d      = we_i;
          if (store_data_i && we_i) begin
            word_wr_o  = 1'b1;
            word_idx_o = '0;
            count_nxt  = 4'd1;
          end else begin
            count_nxt  = 4'd0;
          end
          if (message_complete_i) begin
            commit_o = 1'b1;
            count_d  = '0;
          end else begin
            count_d  = count_nxt;
            state_d  = ST_FILL;
          end
        end else begin
          count_d = '0;
        end
      end
      ST_FILL: begin
        if (abort_i) begin
          count_d = '0;
          state_d = ST_IDLE;
        end else begin
          if (store_data_i && we_q) begin
            if (count_q == MAX_CNT) begin
              overflow_d = 1'b1;
            end else begin
              word_wr_o = 1'b1;
              count_nxt = count_q + 4'd1;
            end
          end else begin
            count_nxt = count_q;
          end
          if (message_complete_i) begin
            commit_o = 1'b1;
            count_d  = '0;
            state_d  = ST_IDLE;
          end else begin
            count_d  = count_nxt;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  assign commit_count_o = count_nxt;
  assign overflow_o     = overflow_q;
endmodule

// File: rtl/packet_queue.sv
// MESSAGE2PACKET queue: circular slot store filled by the assembler and
// drained one packet per grant toward the output-port flit buffer.
module packet_queue
  import packet_queue_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  packet_queue_if.slave bus
);
  logic [QUEUE_WIDTH-1:0]         valid_q, valid_d;
  logic [HEAD_FIELDS_W-1:0]       head_q  [QUEUE_WIDTH];
  logic [HEAD_FIELDS_W-1:0]       head_d  [QUEUE_WIDTH];
  logic [BUS_DATA_WIDTH-1:0]      data_q  [QUEUE_WIDTH][MAX_BURST_LENGHT];
  logic [BUS_DATA_WIDTH-1:0]      data_d  [QUEUE_WIDTH][MAX_BURST_LENGHT];
  logic [N_BITS_BURST_LENGHT-1:0] count_q [QUEUE_WIDTH];
  logic [N_BITS_BURST_LENGHT-1:0] count_d [QUEUE_WIDTH];
  logic [N_BITS_POINTER-1:0]      tail_pointer_q, tail_pointer_d;
  logic [N_BITS_POINTER-1:0]      head_pointer_q, head_pointer_d;

  logic                           head_wr_s, word_wr_s, commit_s, space_s, req_s;
  logic [N_BITS_BURST_LENGHT-2:0] word_idx_s;
  logic [BUS_DATA_WIDTH-1:0]      word_s;
  logic [N_BITS_BURST_LENGHT-1:0] commit_count_s, cur_count_s;
  logic [OUT_LINK_W-1:0]          out_link_s;
  flit_type_e                     head_type_s;

  assign space_s = !valid_q[tail_pointer_q];
  assign req_s   = valid_q[head_pointer_q];

  packet_queue_assembler u_asm (
    .clk                (clk),
    .rst                (rst),
    .space_available_i  (space_s),
    .store_data_i       (bus.store_data_i),
    .message_complete_i (bus.message_complete_i),
    .abort_i            (bus.abort_i),
    .we_i               (bus.we_i),
    .data_i             (bus.data_i),
    .sel_i              (bus.sel_i),
    .head_wr_o          (head_wr_s),
    .word_wr_o          (word_wr_s),
    .word_idx_o         (word_idx_s),
    .word_o             (word_s),
    .commit_o           (commit_s),
    .commit_count_o     (commit_count_s),
    .overflow_o         (bus.overflow_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= '0;
      tail_pointer_q <= '0;
      head_pointer_q <= '0;
      for (int s = 0; s < QUEUE_WIDTH; s++) begin
        head_q[s]  <= '0;
        count_q[s] <= '0;
        for (int w = 0; w < MAX_BURST_LENGHT; w++) begin
          data_q[s][w] <= '0;
        end
      end
    end else begin
      valid_q        <= valid_d;
      tail_pointer_q <= tail_pointer_d;
      head_pointer_q <= head_pointer_d;
      head_q         <= head_d;
      count_q        <= count_d;
      data_q         <= data_d;
    end
  end

  // Commit targets the (free) tail slot and grant the (valid) head slot, so both may fire together.
  always_comb begin
    valid_d        = valid_q;
    head_d         = head_q;
    data_d         = data_q;
    count_d        = count_q;
    tail_pointer_d = tail_pointer_q;
    head_pointer_d = head_pointer_q;
    if (head_wr_s) begin
      head_d[tail_pointer_q] = {bus.tgc_i, bus.tga_i, bus.address_i};
    end else begin
      head_d[tail_pointer_q] = head_q[tail_pointer_q];
    end
    if (word_wr_s) begin
      data_d[tail_pointer_q][word_idx_s] = word_s;
    end else begin
      data_d[tail_pointer_q][word_idx_s] = data_q[tail_pointer_q][word_idx_s];
    end
    if (commit_s) begin
      valid_d[tail_pointer_q] = 1'b1;
      count_d[tail_pointer_q] = commit_count_s;
      tail_pointer_d          = tail_pointer_q + 2'd1;
    end else begin
      tail_pointer_d          = tail_pointer_q;
    end
    if (bus.g_msg_to_pkt_i && req_s) begin
      valid_d[head_pointer_q] = 1'b0;
      head_pointer_d          = head_pointer_q + 2'd1;
    end else begin
      head_pointer_d          = head_pointer_q;
    end
  end

  // Flits past the stored word count are forced to zero so stale slot data never leaks.
  always_comb begin
    cur_count_s = count_q[head_pointer_q];
    if (cur_count_s != 4'd0) begin
      head_type_s = FLIT_HEAD;
    end else begin
      head_type_s = FLIT_HEAD_TAIL;
    end
    out_link_s = '0;
    out_link_s[BUS_DATA_WIDTH-1:0] = {head_type_s, head_q[head_pointer_q]};
    for (int i = 0; i < MAX_BURST_LENGHT; i++) begin
      if (N_BITS_BURST_LENGHT'(i) < cur_count_s) begin
        out_link_s[(i+1)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = data_q[head_pointer_q][i];
      end else begin
        out_link_s[(i+1)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = '0;
      end
    end
  end

  assign bus.space_available_o = space_s;
  assign bus.r_msg_to_pkt_o    = req_s;
  assign bus.out_link_o        = out_link_s;
  assign bus.out_len_o         = cur_count_s + 4'd1;
endmodule

// File: tb/tb_packet_queue.sv
// Scoreboard bench: each committed message pushes its expected packet; each
// granted packet is popped and compared against the DUT output link.
module tb_packet_queue;
  import packet_queue_pkg::*;

  typedef struct {
    logic [3:0]   len;
    logic [287:0] link;
  } pkt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  packet_queue_if bus();

  packet_queue dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ovf_cnt  = 0;
  pkt_t exp_q[$];
  logic [31:0] wbuf [0:15];

  always @(negedge clk) begin
    if (bus.overflow_o) ovf_cnt++;
  end

  task automatic check_eq(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
    return m;
  endfunction

  task automatic fill_buf(input int n);
    for (int k = 0; k < n; k++) wbuf[k] = $urandom;
  endtask

  // Called on a negedge; returns on the negedge after the commit edge.
  task automatic send_msg(input logic [21:0] addr, input logic [3:0] tga, input logic [3:0] tgc,
                          input logic we, input int n, input logic [3:0] sel);
    pkt_t p;
    int cnt;
    bus.address_i = addr; bus.tga_i = tga; bus.tgc_i = tgc; bus.we_i = we; bus.sel_i = sel;
    if (we && n > 0) begin
      for (int k = 0; k < n; k++) begin
        bus.store_data_i = 1'b1;
        bus.data_i = wbuf[k];
        bus.message_complete_i = (k == n - 1);
        @(negedge clk);
      end
    end else begin
      bus.message_complete_i = 1'b1;
      @(negedge clk);
    end
    bus.store_data_i = 1'b0; bus.message_complete_i = 1'b0;
    cnt = we ? ((n > 8) ? 8 : n) : 0;
    p.len  = 4'(cnt + 1);
    p.link = '0;
    p.link[31:0] = {(cnt != 0) ? 2'b00 : 2'b11, tgc, tga, addr};
    for (int k = 0; k < cnt; k++) p.link[(k+1)*32 +: 32] = bmask(wbuf[k], sel);
    exp_q.push_back(p);
  endtask

  task automatic store_partial(input logic [21:0] addr, input int n);
    bus.address_i = addr; bus.tga_i = 4'd1; bus.tgc_i = 4'd1; bus.we_i = 1'b1; bus.sel_i = 4'hF;
    for (int k = 0; k < n; k++) begin
      bus.store_data_i = 1'b1;
      bus.data_i = wbuf[k];
      @(negedge clk);
    end
    bus.store_data_i = 1'b0;
  endtask

  task automatic deliver(input string tag);
    pkt_t p;
    int waited;
    waited = 0;
    while (!bus.r_msg_to_pkt_o && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tag, "_req"}, 288'(bus.r_msg_to_pkt_o), 288'(1'b1));
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_underflow"}, 288'(exp_q.size()), 288'(1));
    end else begin
      p = exp_q.pop_front();
      check_eq({tag, "_len"}, 288'(bus.out_len_o), 288'(p.len));
      check_eq({tag, "_link"}, bus.out_link_o, p.link);
    end
    bus.g_msg_to_pkt_i = 1'b1;
    @(negedge clk);
    bus.g_msg_to_pkt_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   288'(bus.r_msg_to_pkt_o),    288'(1'b0));
    check_eq({tag, "_space"}, 288'(bus.space_available_o), 288'(1'b1));
    check_eq({tag, "_ovf"},   288'(bus.overflow_o),        288'(1'b0));
    check_eq({tag, "_len"},   288'(bus.out_len_o),         288'(4'd1));
  endtask

  initial begin
    bus.address_i = '0; bus.tga_i = '0; bus.tgc_i = '0; bus.we_i = 1'b0;
    bus.data_i = '0; bus.sel_i = '0; bus.store_data_i = 1'b0;
    bus.message_complete_i = 1'b0; bus.abort_i = 1'b0; bus.g_msg_to_pkt_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // 3-chunk write; request must be up the cycle after the commit edge
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC;
    send_msg(22'h123, 4'd2, 4'd5, 1'b1, 3, 4'hF);
    check_eq("w3_latency", 288'(bus.r_msg_to_pkt_o), 288'(1'b1));
    check_eq("w3_len", 288'(bus.out_len_o), 288'(4'd4));
    deliver("w3");

    send_msg(22'h40, 4'd0, 4'd3, 1'b0, 0, 4'hF);
    deliver("read");

    wbuf[0] = 32'hFFFF_FFFF;
    send_msg(22'h77, 4'd4, 4'd6, 1'b1, 1, 4'b0101);
    check_eq("bmask_word", 288'(bus.out_link_o[63:32]), 288'(32'h00FF_00FF));
    deliver("bmask");

    // fill all slots, then a store while full must be ignored
    for (int m = 0; m < 4; m++) begin
      fill_buf(2);
      send_msg(22'(m + 22'h100), 4'(m), 4'(m + 1), 1'b1, 2, 4'hF);
    end
    check_eq("full_space", 288'(bus.space_available_o), 288'(1'b0));
    bus.we_i = 1'b1; bus.store_data_i = 1'b1; bus.message_complete_i = 1'b1;
    bus.data_i = 32'hDEAD_BEEF; bus.address_i = 22'h3FF;
    @(negedge clk);
    bus.store_data_i = 1'b0; bus.message_complete_i = 1'b0;
    check_eq("full_space_hold", 288'(bus.space_available_o), 288'(1'b0));
    deliver("full0");
    check_eq("space_after_grant", 288'(bus.space_available_o), 288'(1'b1));
    fill_buf(3);
    send_msg(22'h2AA, 4'd9, 4'd10, 1'b1, 3, 4'hF);
    for (int m = 0; m < 4; m++) deliver("wrap");
    check_eq("wrap_empty_req", 288'(bus.r_msg_to_pkt_o), 288'(1'b0));

    // abort after two chunks: nothing committed, slot reused
    fill_buf(2);
    store_partial(22'h155, 2);
    bus.abort_i = 1'b1; bus.store_data_i = 1'b1; bus.message_complete_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0; bus.store_data_i = 1'b0; bus.message_complete_i = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("abort_no_req", 288'(bus.r_msg_to_pkt_o), 288'(1'b0));
    check_eq("abort_space", 288'(bus.space_available_o), 288'(1'b1));
    fill_buf(1);
    send_msg(22'h156, 4'd3, 4'd3, 1'b1, 1, 4'hF);
    deliver("post_abort");

    // nine chunks: last one dropped with a single overflow pulse
    ovf_cnt = 0;
    fill_buf(9);
    send_msg(22'h1F0, 4'd7, 4'd8, 1'b1, 9, 4'hF);
    @(negedge clk);
    check_eq("ovf_pulses", 288'(ovf_cnt), 288'(1));
    check_eq("ovf_len", 288'(bus.out_len_o), 288'(4'd9));
    deliver("ovf");

    // reset in the middle of a fill with two slots pending
    for (int m = 0; m < 2; m++) begin
      fill_buf(2);
      send_msg(22'(m + 22'h300), 4'd1, 4'd2, 1'b1, 2, 4'hF);
    end
    fill_buf(2);
    store_partial(22'h310, 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("midreset");
    fill_buf(4);
    send_msg(22'h321, 4'd12, 4'd13, 1'b1, 4, 4'b1100);
    deliver("post_reset");
    check_eq("sb_empty", 288'(exp_q.size()), 288'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
